// File: rtl/argmax_collect_pkg.sv
// rtl/argmax_collect_pkg.sv - shared NPU constants: score width, class count, FSM encoding
package argmax_collect_pkg;

    localparam int ARGMAX_WIDTH       = 8;
    localparam int ARGMAX_NUM_CLASSES = 10;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_RESULT  = 2'd2;

    // Index width for a class count; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/argmax_collect_if.sv
// rtl/argmax_collect_if.sv - score stream in, argmax result out
interface argmax_collect_if
    import argmax_collect_pkg::*;
#(
    parameter int WIDTH       = ARGMAX_WIDTH,
    parameter int NUM_CLASSES = ARGMAX_NUM_CLASSES
);
    localparam int IDX_W = idx_width(NUM_CLASSES);

    logic             START;
    logic             EN_IN;
    logic [WIDTH-1:0] DATA_IN;
    logic [IDX_W-1:0] CLASS_OUT;
    logic [WIDTH-1:0] MAX_OUT;
    logic             DONE;
    logic             BUSY;
    logic             OVERRUN;

    // Upstream side: issues frames and scores, observes the result.
    modport master (
        output START, EN_IN, DATA_IN,
        input  CLASS_OUT, MAX_OUT, DONE, BUSY, OVERRUN
    );

    // Collector side.
    modport slave (
        input  START, EN_IN, DATA_IN,
        output CLASS_OUT, MAX_OUT, DONE, BUSY, OVERRUN
    );
endinterface

// File: rtl/argmax_collect.sv
// rtl/argmax_collect.sv - serial signed argmax over one frame of class scores
module argmax_collect
    import argmax_collect_pkg::*;
#(
    parameter int WIDTH       = ARGMAX_WIDTH,
    parameter int NUM_CLASSES = ARGMAX_NUM_CLASSES
) (
    input  logic              CLKEXT,
    input  logic              CLRN_ARGMAX,
    argmax_collect_if.slave   bus
);
    localparam int IDX_W = idx_width(NUM_CLASSES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [IDX_W-1:0] count;
    logic [WIDTH-1:0] run_max;
    logic [IDX_W-1:0] run_idx;
    logic [IDX_W-1:0] class_q;
    logic [WIDTH-1:0] max_q;
    logic             overrun_q;

    logic             take;
    logic [WIDTH-1:0] win_max;
    logic [IDX_W-1:0] win_idx;

    // Winner after the current sample: the first sample always loads, later
    // ones only on strictly greater so ties keep the lower index.
    always_comb begin
        take    = (count == '0) || ($signed(bus.DATA_IN) > $signed(run_max));
        win_max = take ? bus.DATA_IN : run_max;
        win_idx = take ? count : run_idx;
    end

    // Frame FSM, sample counter, running winner and result registers.
    always_ff @(posedge CLKEXT or negedge CLRN_ARGMAX) begin
        if (!CLRN_ARGMAX) begin
            state     <= ST_IDLE;
            count     <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            class_q   <= '0;
            max_q     <= '0;
            overrun_q <= 1'b0;
        end else if (bus.START) begin
            // START restarts from any state; a coincident sample is dropped.
            state     <= ST_COLLECT;
            count     <= '0;
            run_max   <= MOST_NEG;
            run_idx   <= '0;
            overrun_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.EN_IN) overrun_q <= 1'b1;
                end
                ST_COLLECT: begin
                    if (bus.EN_IN) begin
                        run_max <= win_max;
                        run_idx <= win_idx;
                        if (count == LAST_IDX) begin
                            state   <= ST_RESULT;
                            count   <= '0;
                            class_q <= win_idx;
                            max_q   <= win_max;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_RESULT: begin
                    state <= ST_IDLE;
                    if (bus.EN_IN) overrun_q <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.CLASS_OUT = class_q;
    assign bus.MAX_OUT   = max_q;
    assign bus.DONE      = (state == ST_RESULT);
    assign bus.BUSY      = (state == ST_COLLECT);
    assign bus.OVERRUN   = overrun_q;

endmodule

// File: tb/tb_argmax_collect.sv
// tb/tb_argmax_collect.sv - directed self-checking bench for argmax_collect
module tb_argmax_collect;

    typedef logic [7:0] frame_t [10];

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   done_cnt;
    int   d0;

    frame_t f_a   = '{8'h03, 8'hFB, 8'h07, 8'h02, 8'h07, 8'h00, 8'h01, 8'h80, 8'h06, 8'h04};
    frame_t f_neg = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    frame_t f_up  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100};

    argmax_collect_if #(.WIDTH(8), .NUM_CLASSES(10)) bus ();

    argmax_collect #(.WIDTH(8), .NUM_CLASSES(10)) dut (
        .CLKEXT      (clk),
        .CLRN_ARGMAX (rst_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DONE pulses seen over the whole run.
    always @(negedge clk) if (bus.DONE === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // START with a coincident sample that must not be counted.
    task automatic start_frame();
        bus.START   = 1'b1;
        bus.EN_IN   = 1'b1;
        bus.DATA_IN = 8'h7F;
        tick();
        bus.START = 1'b0;
        bus.EN_IN = 1'b0;
        chk("start_busy", {31'd0, bus.BUSY}, 32'd1);
        chk("start_overrun", {31'd0, bus.OVERRUN}, 32'd0);
    endtask

    task automatic run_frame(input frame_t f, input int gap, input logic [3:0] exp_cls,
                             input logic [7:0] exp_max, input logic start_next);
        for (int i = 0; i < 10; i++) begin
            bus.EN_IN   = 1'b1;
            bus.DATA_IN = f[i];
            tick();
            bus.EN_IN = 1'b0;
            if (i < 9) begin
                chk("mid_busy", {31'd0, bus.BUSY}, 32'd1);
                chk("mid_done", {31'd0, bus.DONE}, 32'd0);
                for (int g = 0; g < gap; g++) begin
                    bus.DATA_IN = 8'h7F;
                    tick();
                    chk("gap_busy", {31'd0, bus.BUSY}, 32'd1);
                    chk("gap_done", {31'd0, bus.DONE}, 32'd0);
                end
            end
        end
        chk("res_done", {31'd0, bus.DONE}, 32'd1);
        chk("res_busy", {31'd0, bus.BUSY}, 32'd0);
        chk("res_class", {28'd0, bus.CLASS_OUT}, {28'd0, exp_cls});
        chk("res_max", {24'd0, bus.MAX_OUT}, {24'd0, exp_max});
        bus.START = start_next;
        tick();
        bus.START = 1'b0;
        chk("post_done", {31'd0, bus.DONE}, 32'd0);
        chk("post_busy", {31'd0, bus.BUSY}, {31'd0, start_next});
        chk("post_class", {28'd0, bus.CLASS_OUT}, {28'd0, exp_cls});
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        done_cnt    = 0;
        rst_n       = 1'b0;
        bus.START   = 1'b0;
        bus.EN_IN   = 1'b0;
        bus.DATA_IN = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_class", {28'd0, bus.CLASS_OUT}, 32'd0);
        chk("rst_max", {24'd0, bus.MAX_OUT}, 32'd0);
        chk("rst_done", {31'd0, bus.DONE}, 32'd0);
        chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
        chk("rst_overrun", {31'd0, bus.OVERRUN}, 32'd0);
        rst_n = 1'b1;

        // Basic frame, tie at index 4 loses to index 2.
        start_frame();
        run_frame(f_a, 0, 4'd2, 8'h07, 1'b0);
        chk("done_cnt_a", done_cnt, 32'd1);

        // All most-negative scores: first sample still loads.
        start_frame();
        run_frame(f_neg, 0, 4'd0, 8'h80, 1'b0);

        // Gapped enables, then START during RESULT restarts while DONE still pulses.
        start_frame();
        run_frame(f_a, 2, 4'd2, 8'h07, 1'b1);
        chk("done_cnt_gap", done_cnt, 32'd3);

        // Restart after 5 samples; coincident sample is dropped.
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            bus.EN_IN   = 1'b1;
            bus.DATA_IN = f_a[i];
            tick();
        end
        bus.START   = 1'b1;
        bus.EN_IN   = 1'b1;
        bus.DATA_IN = 8'h7F;
        tick();
        bus.START = 1'b0;
        bus.EN_IN = 1'b0;
        chk("restart_busy", {31'd0, bus.BUSY}, 32'd1);
        run_frame(f_up, 0, 4'd9, 8'd100, 1'b0);
        chk("restart_one_done", done_cnt - d0, 32'd1);

        // Reset mid-frame discards the partial frame.
        d0 = done_cnt;
        start_frame();
        for (int i = 0; i < 6; i++) begin
            bus.EN_IN   = 1'b1;
            bus.DATA_IN = f_up[i];
            tick();
        end
        bus.EN_IN = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("mid_rst_class", {28'd0, bus.CLASS_OUT}, 32'd0);
        chk("mid_rst_max", {24'd0, bus.MAX_OUT}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.BUSY}, 32'd0);
        tick();
        rst_n = 1'b1;
        chk("mid_rst_done", {31'd0, bus.DONE}, 32'd0);
        chk("mid_rst_no_done", done_cnt - d0, 32'd0);
        start_frame();
        run_frame(f_a, 0, 4'd2, 8'h07, 1'b0);

        // EN_IN while idle sets OVERRUN; next START clears it.
        chk("ovr_before", {31'd0, bus.OVERRUN}, 32'd0);
        bus.EN_IN   = 1'b1;
        bus.DATA_IN = 8'h7F;
        tick();
        tick();
        bus.EN_IN = 1'b0;
        chk("ovr_set", {31'd0, bus.OVERRUN}, 32'd1);
        chk("ovr_class", {28'd0, bus.CLASS_OUT}, 32'd2);
        chk("ovr_max", {24'd0, bus.MAX_OUT}, 32'd7);
        chk("ovr_done", {31'd0, bus.DONE}, 32'd0);
        chk("ovr_busy", {31'd0, bus.BUSY}, 32'd0);
        start_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
